avg_filter_ctrl: RTL and testbench
==================================

// Module: avg_filter_ctrl
// PURPOSE
//  Sequencer for averaging_filter. Accepts a raster pixel stream (valid/ready) and assembles one
//  R_I x C_I frame. Drives the kernel, enables the filter for its pipeline latency, and captures
//  final_img. Streams the filtered frame out in raster order. Sits between the camera capture
//  path and the display/frame-buffer writer.
// PARAMETERS
//  R_I      5  image rows
//  C_I      5  image columns
//  W_I      8  pixel width (bits)
//  R_K      3  kernel rows
//  C_K      3  kernel columns
//  W_K      8  kernel coefficient width
//  LATENCY  $clog2(R_K*C_K)+1  filter pipeline latency in cen-cycles (localparam, not overridable)
// PORTS
//  clk          in   1            system clock, all logic on posedge
//  rstn         in   1            asynchronous active-low reset
//  s_valid      in   1            input pixel valid
//  s_ready      out  1            input pixel accepted when s_valid&&s_ready
//  s_data       in   W_I          input pixel, raster order (row 0 col 0 first)
//  s_last       in   1            marks final pixel of frame
//  m_valid      out  1            output pixel valid
//  m_ready      in   1            downstream ready
//  m_data       out  W_I          filtered pixel, raster order
//  m_last       out  1            high with pixel (R_I-1,C_I-1)
//  f_cen        out  1            averaging_filter clock enable
//  f_img        out  R_I*C_I*W_I  frame to filter (packed img_t)
//  f_kernel     out  R_K*C_K*W_K  kernel to filter (packed kernel_t)
//  f_final_img  in   R_I*C_I*W_I  filter result
//  busy         out  1            high in any state except LOAD with pixel count 0
//  frame_done   out  1            1-cycle pulse when m_last handshake completes
//  err_last     out  1            1-cycle pulse on s_last/pixel-count mismatch
// BEHAVIOUR
//  Reset: state=LOAD, counters 0, s_ready=1, m_valid=0, m_last=0, f_cen=0, frame_done=0,
//    err_last=0, f_img=0, f_kernel=all 1.
//  FSM LOAD -> RUN -> OUT -> LOAD.
//  LOAD: s_ready=1. Each accepted pixel is written to f_img[row][col]; col++, wraps at C_I-1 to 0
//    with row++.
//    - Accepted with s_last=1 at count R_I*C_I-1 -> RUN.
//    - s_last=1 at any other count, or count reaches R_I*C_I-1 with s_last=0: pulse err_last,
//      clear counters, stay in LOAD. Partial frame is discarded; no filter run.
//  RUN: s_ready=0, f_cen=1 for exactly LATENCY cycles (f_img held stable). On the cycle after
//    the last cen-cycle, register f_final_img into an output buffer and go to OUT.
//  OUT: m_valid=1, m_data=buffer[row][col]. Advance only on m_valid&&m_ready; m_data is stable
//    while stalled. On the last-pixel handshake: pulse frame_done, clear counters, go to LOAD.
//    s_ready=0 in OUT (no overlap of load and drain).
//  Widths: counters $clog2(R_I), $clog2(C_I). No arithmetic on pixels; division is inside the
//    filter.
//  Reset mid-operation (any state) aborts immediately to reset values; in-flight frame is lost.
//  s_valid/m_ready ignored outside LOAD/OUT respectively.
// CONFIGURATION
//  AVG_KERNEL_LOAD_EN defined: extra ports k_wr(in,1), k_addr(in,$clog2(R_K*C_K)),
//    k_data(in,W_K).
//    - Writes update f_kernel[k_addr] only in LOAD; writes in RUN/OUT are dropped.
//    - Reset value is all 1.
//  Undefined: f_kernel is constant all 1; no k_* ports.
// STRUCTURE
//  Package avg_filter_pkg: R_I/C_I/W_I/R_K/C_K/W_K defaults, img_t, kernel_t,
//    state_e {LOAD,RUN,OUT}, LATENCY.
//  Sub-module raster_cnt: row/col counter with en, clr, and last flag; instantiated for LOAD and
//    for OUT. Controller and averaging_filter are instantiated side by side in the top level.
// TESTING (bench instantiates avg_filter_ctrl + averaging_filter, default params)
//  1. Ramp frame 0..24, s_last on pixel 24, m_ready=1
//     -> out(0,0)=1, out(2,2)=12, out(4,4)=(18+19+23+24)/9=9, m_last on 25th pixel,
//        frame_done 1 pulse.
//  2. Same frame, m_ready toggling 1/0 each cycle -> identical 25-pixel sequence; m_data stable
//     during stalls.
//  3. s_last on pixel 10 -> err_last pulse; no f_cen; next full frame filters correctly.
//  4. rstn low for 1 cycle during RUN (cen cycle 2) -> all outputs at reset values; subsequent
//     frame correct.
//  5. All 255 frame -> out(0,0)=113 (1020/9), out(2,2)=255; f_cen high exactly LATENCY=5 cycles.
//  6. AVG_KERNEL_LOAD_EN: write k[4]=0 in LOAD, all-9 frame -> out(2,2)=8; write during OUT is
//     ignored.

Source files
------------

// File: rtl/avg_filter_pkg.sv
// Shared defaults, frame/kernel types, FSM state encoding and sizing helpers
// for the averaging-filter sequencer and the filter it drives.
package avg_filter_pkg;

  localparam int DEF_R_I = 5;  // image rows
  localparam int DEF_C_I = 5;  // image columns
  localparam int DEF_W_I = 8;  // pixel width
  localparam int DEF_R_K = 3;  // kernel rows
  localparam int DEF_C_K = 3;  // kernel columns
  localparam int DEF_W_K = 8;  // kernel coefficient width

  // Filter pipeline depth in cen-cycles: adder-tree depth plus the divide stage.
  function automatic int calc_latency(input int taps);
    return $clog2(taps) + 1;
  endfunction

  // Counter width that stays legal for a dimension of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LATENCY = calc_latency(DEF_R_K * DEF_C_K);

  // Element [row][col] sits at bit offset (row*C_I + col)*W_I.
  typedef logic [DEF_R_I-1:0][DEF_C_I-1:0][DEF_W_I-1:0] img_t;
  typedef logic [DEF_R_K*DEF_C_K-1:0][DEF_W_K-1:0]       kernel_t;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    OUT
  } state_e;

endpackage

// File: rtl/avg_filter_ctrl_if.sv
// Raster pixel stream: valid/ready handshake with an end-of-frame marker.
interface avg_filter_ctrl_if #(
  parameter int W = avg_filter_pkg::DEF_W_I
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/averaging_filter.sv
// Zero-padded 2-D weighted average: each output pixel is the kernel-weighted
// sum of its neighbourhood divided by the number of taps. The result passes
// through a cen-gated register pipeline, so it appears calc_latency(taps)
// enabled cycles after img is presented.
module averaging_filter
  import avg_filter_pkg::*;
#(
  parameter int R_I = DEF_R_I,
  parameter int C_I = DEF_C_I,
  parameter int W_I = DEF_W_I,
  parameter int R_K = DEF_R_K,
  parameter int C_K = DEF_C_K,
  parameter int W_K = DEF_W_K
) (
  input  logic                             clk,
  input  logic                             cen,
  input  logic [R_I-1:0][C_I-1:0][W_I-1:0] img,
  input  logic [R_K*C_K-1:0][W_K-1:0]      kernel,
  output logic [R_I-1:0][C_I-1:0][W_I-1:0] final_img
);
  localparam int NK  = R_K * C_K;
  localparam int LAT = calc_latency(NK);
  localparam int SW  = W_I + W_K + cnt_width(NK);
  localparam int PR  = R_I + R_K - 1;
  localparam int PC  = C_I + C_K - 1;

  typedef logic [R_I-1:0][C_I-1:0][W_I-1:0] pix_t;

  logic [PR-1:0][PC-1:0][W_I-1:0] pad;
  logic [SW-1:0]                  acc;
  pix_t                           avg;
  pix_t                           pipe [LAT];

  // Image placed inside a zero border so every window index is in range.
  // NOTE: always_comb assigns every target a default first, so no latch is inferred.
  always_comb begin
    pad = '0;
    for (int r = 0; r < R_I; r++) begin
      for (int c = 0; c < C_I; c++) begin
        pad[r + R_K/2][c + C_K/2] = img[r][c];
      end
    end
  end

  // Weighted window sum and divide by tap count, truncated to pixel width.
  always_comb begin
    avg = '0;
    acc = '0;
    for (int r = 0; r < R_I; r++) begin
      for (int c = 0; c < C_I; c++) begin
        acc = '0;
        for (int kr = 0; kr < R_K; kr++) begin
          for (int kc = 0; kc < C_K; kc++) begin
            acc = acc + SW'(pad[r + kr][c + kc]) * SW'(kernel[kr*C_K + kc]);
          end
        end
        avg[r][c] = W_I'(acc / SW'(NK));
      end
    end
  end

  // Latency pipeline, advanced only while enabled.
  // NOTE: pure datapath storage carries no reset; it is always refilled before it is read.
  always_ff @(posedge clk) begin
    if (cen) begin
      pipe[0] <= avg;
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign final_img = pipe[LAT-1];

endmodule

// File: rtl/raster_cnt.sv
// Row/column raster position counter. col wraps to 0 after COLS-1 and
// carries into row; last flags the final position of the frame.
module raster_cnt
  import avg_filter_pkg::*;
#(
  parameter int ROWS = DEF_R_I,
  parameter int COLS = DEF_C_I
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic                       clr,
  output logic [cnt_width(ROWS)-1:0] row,
  output logic [cnt_width(COLS)-1:0] col,
  output logic                       last
);
  localparam int RW = cnt_width(ROWS);
  localparam int CW = cnt_width(COLS);

  // Position register; clear has priority over advance.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == CW'(COLS - 1)) begin
        col <= '0;
        row <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));

endmodule

// File: rtl/avg_filter_ctrl.sv
// Sequencer for averaging_filter: assembles one raster frame from the input
// stream (LOAD), enables the filter for its pipeline latency (RUN), then
// streams the captured result out in raster order (OUT).
// Optional feature macro AVG_KERNEL_LOAD_EN: adds k_wr/k_addr/k_data so the
// kernel can be rewritten while idle in LOAD; otherwise the kernel is all 1.
module avg_filter_ctrl
  import avg_filter_pkg::*;
#(
  parameter int R_I = DEF_R_I,
  parameter int C_I = DEF_C_I,
  parameter int W_I = DEF_W_I,
  parameter int R_K = DEF_R_K,
  parameter int C_K = DEF_C_K,
  parameter int W_K = DEF_W_K
) (
  input  logic                             clk,
  input  logic                             rstn,
  avg_filter_ctrl_if.slave                 s,
  avg_filter_ctrl_if.master                m,
  output logic                             f_cen,
  output logic [R_I-1:0][C_I-1:0][W_I-1:0] f_img,
  output logic [R_K*C_K-1:0][W_K-1:0]      f_kernel,
  input  logic [R_I-1:0][C_I-1:0][W_I-1:0] f_final_img,
`ifdef AVG_KERNEL_LOAD_EN
  input  logic                             k_wr,
  input  logic [$clog2(R_K*C_K)-1:0]       k_addr,
  input  logic [W_K-1:0]                   k_data,
`endif
  output logic                             busy,
  output logic                             frame_done,
  output logic                             err_last
);
  localparam int NK         = R_K * C_K;
  localparam int CEN_CYCLES = calc_latency(NK);
  localparam int RW         = cnt_width(R_I);
  localparam int CLW        = cnt_width(C_I);
  localparam int LW         = cnt_width(CEN_CYCLES + 1);

  typedef logic [R_I-1:0][C_I-1:0][W_I-1:0] frame_t;

  state_e        state_q, state_d;
  frame_t        img_q;
  frame_t        out_buf;
  logic [LW-1:0] cen_cnt;
  logic          cen_done;
  logic          capture;

  logic [RW-1:0]  ld_row, out_row;
  logic [CLW-1:0] ld_col, out_col;
  logic           ld_en, ld_clr, ld_last;
  logic           out_en, out_clr, out_last;

  raster_cnt #(.ROWS(R_I), .COLS(C_I)) u_ld_cnt (
    .clk  (clk),
    .rstn (rstn),
    .en   (ld_en),
    .clr  (ld_clr),
    .row  (ld_row),
    .col  (ld_col),
    .last (ld_last)
  );

  raster_cnt #(.ROWS(R_I), .COLS(C_I)) u_out_cnt (
    .clk  (clk),
    .rstn (rstn),
    .en   (out_en),
    .clr  (out_clr),
    .row  (out_row),
    .col  (out_col),
    .last (out_last)
  );

  assign cen_done = (cen_cnt == LW'(CEN_CYCLES));

  // Next-state and handshake/strobe decode.
  always_comb begin
    state_d    = state_q;
    s.ready    = 1'b0;
    m.valid    = 1'b0;
    f_cen      = 1'b0;
    ld_en      = 1'b0;
    ld_clr     = 1'b0;
    out_en     = 1'b0;
    out_clr    = 1'b0;
    err_last   = 1'b0;
    frame_done = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      LOAD: begin
        s.ready = 1'b1;
        if (s.valid) begin
          if (s.last && ld_last) begin
            ld_clr  = 1'b1;
            state_d = RUN;
          end else if (s.last || ld_last) begin
            // Frame length disagrees with s_last: drop the partial frame.
            ld_clr   = 1'b1;
            err_last = 1'b1;
          end else begin
            ld_en = 1'b1;
          end
        end
      end
      RUN: begin
        if (cen_done) begin
          capture = 1'b1;
          state_d = OUT;
        end else begin
          f_cen = 1'b1;
        end
      end
      OUT: begin
        m.valid = 1'b1;
        if (m.ready) begin
          if (out_last) begin
            out_clr    = 1'b1;
            frame_done = 1'b1;
            state_d    = LOAD;
          end else begin
            out_en = 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // Counts enabled filter cycles while in RUN; idles at zero elsewhere.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 cen_cnt <= '0;
    else if (state_q != RUN)   cen_cnt <= '0;
    else if (!cen_done)        cen_cnt <= cen_cnt + 1'b1;
  end

  // Frame assembly: each accepted pixel lands at the current raster position.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              img_q <= '0;
    else if (state_q == LOAD && s.valid)    img_q[ld_row][ld_col] <= s.data;
  end

  // Output buffer loaded once, on the cycle after the final enabled cycle.
  always_ff @(posedge clk) begin
    if (capture) out_buf <= f_final_img;
  end

`ifdef AVG_KERNEL_LOAD_EN
  logic [NK-1:0][W_K-1:0] kern_q;

  // Kernel coefficients, writable only while in LOAD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           kern_q <= {NK{W_K'(1)}};
    else if (k_wr && state_q == LOAD)    kern_q[k_addr] <= k_data;
  end

  assign f_kernel = kern_q;
`else
  assign f_kernel = {NK{W_K'(1)}};
`endif

  assign f_img  = img_q;
  assign m.data = out_buf[out_row][out_col];
  assign m.last = (state_q == OUT) && out_last;
  assign busy   = !((state_q == LOAD) && (ld_row == '0) && (ld_col == '0));

endmodule

// File: tb/tb_avg_filter_ctrl.sv
// Bench for avg_filter_ctrl driving averaging_filter. Expected frames come
// from a plain-arithmetic neighbourhood-average model and are queued when a
// frame is issued; an independent monitor checks every output handshake.
`timescale 1ns/1ps
module tb_avg_filter_ctrl;
  import avg_filter_pkg::*;

  localparam int NPIX = DEF_R_I * DEF_C_I;
  localparam int NK   = DEF_R_K * DEF_C_K;

  typedef struct {
    logic [DEF_W_I-1:0] data;
    logic               last;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  avg_filter_ctrl_if #(.W(DEF_W_I)) s_if ();
  avg_filter_ctrl_if #(.W(DEF_W_I)) m_if ();

  logic    f_cen, busy, frame_done, err_last;
  img_t    f_img, f_final_img;
  kernel_t f_kernel;
`ifdef AVG_KERNEL_LOAD_EN
  logic                    k_wr = 1'b0;
  logic [$clog2(NK)-1:0]   k_addr = '0;
  logic [DEF_W_K-1:0]      k_data = '0;
`endif

  avg_filter_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .s           (s_if),
    .m           (m_if),
    .f_cen       (f_cen),
    .f_img       (f_img),
    .f_kernel    (f_kernel),
    .f_final_img (f_final_img),
`ifdef AVG_KERNEL_LOAD_EN
    .k_wr        (k_wr),
    .k_addr      (k_addr),
    .k_data      (k_data),
`endif
    .busy        (busy),
    .frame_done  (frame_done),
    .err_last    (err_last)
  );

  averaging_filter u_filt (
    .clk       (clk),
    .cen       (f_cen),
    .img       (f_img),
    .kernel    (f_kernel),
    .final_img (f_final_img)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   frame_pix [NPIX];
  int   kmodel [NK];
  logic [DEF_W_I-1:0] cap [NPIX];
  int   cen_total = 0;
  int   err_total = 0;
  int   frames_done = 0;
  int   rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int waited);
    checks++;
    errors++;
    $display("FAIL %s: waited %0d cycles without the expected event", name, waited);
  endtask

  // Reference: zero-padded neighbourhood weighted sum / tap count, raster order.
  function automatic void push_expected();
    int   sum;
    int   rr, cc;
    exp_t e;
    for (int r = 0; r < DEF_R_I; r++) begin
      for (int c = 0; c < DEF_C_I; c++) begin
        sum = 0;
        for (int dr = -(DEF_R_K/2); dr <= DEF_R_K/2; dr++) begin
          for (int dc = -(DEF_C_K/2); dc <= DEF_C_K/2; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (rr >= 0 && rr < DEF_R_I && cc >= 0 && cc < DEF_C_I)
              sum += kmodel[(dr + DEF_R_K/2)*DEF_C_K + dc + DEF_C_K/2] * frame_pix[rr*DEF_C_I + cc];
          end
        end
        e.data = DEF_W_I'((sum / NK) % 256);
        e.last = (r == DEF_R_I-1) && (c == DEF_C_I-1);
        exp_q.push_back(e);
      end
    end
  endfunction

  // Downstream ready pattern: 0 always ready, 1 toggling, 2 random.
  initial begin : ready_drv
    m_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_if.ready = 1'b1;
        1:       m_if.ready = !m_if.ready;
        default: m_if.ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pops on each output handshake; also tracks stalls and strobes.
  initial begin : monitor
    exp_t e;
    logic hold_pending;
    logic [DEF_W_I-1:0] held;
    int   out_idx;
    hold_pending = 1'b0;
    held = '0;
    out_idx = 0;
    forever begin
      @(negedge clk);
      if (f_cen)    cen_total++;
      if (err_last) err_total++;
      if (hold_pending && m_if.valid) check("stall_hold", m_if.data, held);
      hold_pending = 1'b0;
      if (m_if.valid && m_if.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got pixel %0d expected no output", m_if.data);
        end else begin
          e = exp_q.pop_front();
          check("m_data", m_if.data, e.data);
          check("m_last", m_if.last, e.last);
          if (out_idx < NPIX) cap[out_idx] = m_if.data;
          out_idx = e.last ? 0 : out_idx + 1;
        end
        check("frame_done", frame_done, m_if.last);
      end else if (frame_done) begin
        check("frame_done_spurious", frame_done, 1'b0);
      end
      if (frame_done) frames_done++;
      if (m_if.valid && !m_if.ready) begin
        hold_pending = 1'b1;
        held = m_if.data;
      end
    end
  end

  task automatic send_pixel(input logic [DEF_W_I-1:0] d, input logic l);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.last  = l;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = s_if.ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    if (!acc) fail("s_ready_timeout", n);
  endtask

  task automatic send_frame(input int n_pix, input int last_at, input bit gaps);
    for (int i = 0; i < n_pix; i++) begin
      send_pixel(DEF_W_I'(frame_pix[i]), i == last_at);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while ((frames_done < target || exp_q.size() != 0) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) fail("frame_timeout", n);
  endtask

  task automatic run_frame(input bit gaps);
    int c0, target;
    push_expected();
    c0 = cen_total;
    target = frames_done + 1;
    send_frame(NPIX, NPIX - 1, gaps);
    wait_done(target);
    check("cen_len", cen_total - c0, LATENCY);
    check("busy_idle", busy, 1'b0);
  endtask

  task automatic check_reset_vals();
    check("rst_s_ready",    s_if.ready, 1'b1);
    check("rst_m_valid",    m_if.valid, 1'b0);
    check("rst_m_last",     m_if.last, 1'b0);
    check("rst_f_cen",      f_cen, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_err_last",   err_last, 1'b0);
    check("rst_busy",       busy, 1'b0);
    check("rst_f_img_zero", 32'(f_img == '0), 1);
    for (int i = 0; i < NK; i++) check("rst_f_kernel", f_kernel[i], kmodel[i]);
  endtask

  task automatic random_frame();
    for (int i = 0; i < NPIX; i++) frame_pix[i] = $urandom_range(0, 255);
  endtask

  initial begin : stimulus
    int e0, c0, n, target;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    for (int i = 0; i < NK; i++) kmodel[i] = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Ramp frame, always ready
    for (int i = 0; i < NPIX; i++) frame_pix[i] = i;
    rdy_mode = 0;
    run_frame(1'b0);
    check("ramp_out00", cap[0], 1);
    check("ramp_out22", cap[12], 12);
    check("ramp_out44", cap[24], 9);

    // Same frame, downstream toggling
    rdy_mode = 1;
    run_frame(1'b0);
    check("ramp_stall_out44", cap[24], 9);
    rdy_mode = 0;

    // s_last early at pixel 10
    e0 = err_total;
    c0 = cen_total;
    for (int i = 0; i < 11; i++) begin
      send_pixel(DEF_W_I'(i), i == 10);
      if (i == 4) check("busy_loading", busy, 1'b1);
    end
    repeat (3) begin @(posedge clk); #1; end
    check("err_early_pulse", err_total - e0, 1);
    check("err_early_no_cen", cen_total - c0, 0);
    check("err_early_busy", busy, 1'b0);
    random_frame();
    run_frame(1'b0);

    // Full-length frame without s_last
    e0 = err_total;
    c0 = cen_total;
    send_frame(NPIX, -1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("err_nolast_pulse", err_total - e0, 1);
    check("err_nolast_no_cen", cen_total - c0, 0);
    random_frame();
    run_frame(1'b1);

    // Reset asserted on the second enabled filter cycle
    random_frame();
    c0 = cen_total;
    send_frame(NPIX, NPIX - 1, 1'b0);
    n = 0;
    while (cen_total - c0 < 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail("run_entry_timeout", n);
    rstn = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    random_frame();
    run_frame(1'b0);

    // Saturated frame
    for (int i = 0; i < NPIX; i++) frame_pix[i] = 255;
    run_frame(1'b0);
    check("sat_out00", cap[0], 113);
    check("sat_out22", cap[12], 255);

    // Back-to-back frames: s_valid held through RUN/OUT must be ignored
    rdy_mode = 2;
    c0 = cen_total;
    target = frames_done + 2;
    random_frame();
    push_expected();
    send_frame(NPIX, NPIX - 1, 1'b0);
    random_frame();
    push_expected();
    send_frame(NPIX, NPIX - 1, 1'b0);
    wait_done(target);
    check("b2b_cen_len", cen_total - c0, 2 * LATENCY);

    // Random frames with input gaps and random downstream stalls
    for (int f = 0; f < 5; f++) begin
      random_frame();
      run_frame(1'b1);
    end
    rdy_mode = 0;

`ifdef AVG_KERNEL_LOAD_EN
    // Kernel write in LOAD takes effect; write during OUT is dropped
    k_wr = 1'b1; k_addr = 4; k_data = '0;
    @(posedge clk); #1;
    k_wr = 1'b0;
    kmodel[4] = 0;
    check("k_center_written", f_kernel[4], 0);
    for (int i = 0; i < NPIX; i++) frame_pix[i] = 9;
    push_expected();
    target = frames_done + 1;
    send_frame(NPIX, NPIX - 1, 1'b0);
    n = 0;
    while (!m_if.valid && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) fail("out_entry_timeout", n);
    k_wr = 1'b1; k_addr = 0; k_data = '0;
    @(posedge clk); #1;
    k_wr = 1'b0;
    wait_done(target);
    check("k_out22", cap[12], 8);
    check("k_write_in_out_dropped", f_kernel[0], 1);
    random_frame();
    run_frame(1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
